gate_test_seq: RTL and testbench

Self-checking stimulus sequencer for a small combinational gate under test (default: 2-input OR). On `start` it walks every input combination onto the gate inputs, waits a fixed settle time, samples the gate output and compares it against a parameterised truth table. It sits beside the gate in the lab top level, replacing hand-written `initial` stimulus with a clocked, repeatable pass/fail check that reports error count and failing vectors.

---
 rtl/gate_test_seq_pkg.sv | 33 +++
 rtl/gate_test_seq_settle_timer.sv | 41 ++++
 rtl/gate_test_seq.sv | 158 +++++++++++++++
 tb/tb_gate_test_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_seq_pkg.sv
// ----------------------------------------------------------------------------
// gate_test_seq_pkg
//   Shared types and constants for the gate test sequencer.
//   - state_t        : sequencer FSM states (IDLE/HOLD/SAMPLE/DONE)
//   - STATE_W        : state register width
//   - DEFAULT_SETTLE : default settle cycles per vector
//   - TT_OR/AND/XOR  : 2-input truth tables, bit k = output for input k
//   - cnt_width()    : settle counter width for a given SETTLE
// ----------------------------------------------------------------------------
package gate_test_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_SETTLE = 1;

    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_XOR = 4'b0110;

    // Counter only ever needs to reach SETTLE-1; keep at least one bit so
    // SETTLE=1 still yields a legal vector.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/gate_test_seq_settle_timer.sv
// ----------------------------------------------------------------------------
// settle_timer
//   Clear/enable up-counter that flags when it has reached SETTLE-1.
//   Ports:
//     clk   in  clock (rising edge)
//     rst   in  asynchronous active-high reset
//     clr   in  synchronous clear to 0 (wins over en)
//     en    in  count enable
//     term  out counter == SETTLE-1
// ----------------------------------------------------------------------------
module settle_timer
    import gate_test_seq_pkg::*;
#(
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int             CW       = cnt_width(SETTLE);
    localparam logic [CW-1:0]  TERM_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    // Counter parks at the terminal value; the FSM leaves HOLD on that
    // cycle, so it never needs to represent SETTLE itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !term)
            cnt <= cnt + CW'(1);
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/gate_test_seq.sv
// ----------------------------------------------------------------------------
// gate_test_seq
//   Clocked self-checking stimulus sequencer for a small combinational gate.
//   On start, walks dut_in through 0..2**N_IN-1, holds each vector SETTLE
//   cycles, samples dut_out on the following cycle and compares against
//   TRUTH. Reports mismatch count, per-vector fail mask and pass flag.
//
//   Parameters:
//     N_IN    number of gate inputs (1..4)
//     SETTLE  cycles each vector is held before sampling (>=1)
//     TRUTH   expected output table, bit k = expected dut_out for dut_in==k
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     start     in   begin a run (only looked at in IDLE)
//     dut_in    out  vector driven to the gate
//     dut_out   in   gate output (combinational, sampled unregistered)
//     busy      out  high from accepted start through DONE
//     done      out  one-cycle end-of-run pulse
//     pass      out  last completed run had zero mismatches
//     err_cnt   out  mismatch count of current/last run
//     fail_vec  out  bit k set if vector k mismatched
//
//   Build option: GATE_TEST_SEQ_TRACE_EN enables simulation-only $display
//   trace of every sample and a run summary. Hardware is identical.
// ----------------------------------------------------------------------------
module gate_test_seq
    import gate_test_seq_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = DEFAULT_SETTLE,
    parameter logic [(2**N_IN)-1:0]    TRUTH  = TT_OR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [N_IN-1:0]          dut_in,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [N_IN:0]            err_cnt,
    output logic [(2**N_IN)-1:0]     fail_vec
);

    state_t state, state_nxt;

    logic term;
    logic timer_clr;
    logic last_vec;
    logic miss;

    assign last_vec = &dut_in;
    assign miss     = dut_out ^ TRUTH[dut_in];

    // ---------------------------------------------------------------- timer
    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (state == HOLD),
        .term (term)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = HOLD;
                    timer_clr = 1'b1;
                end
            end
            HOLD: begin
                if (term)
                    state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (last_vec) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = HOLD;
                    timer_clr = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------- vector and checker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_in   <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dut_in   <= '0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                    end
                end
                SAMPLE: begin
                    // err_cnt has one spare bit over the vector count, so
                    // it saturates naturally at 2**N_IN without wrapping.
                    if (miss) begin
                        err_cnt          <= err_cnt + (N_IN+1)'(1);
                        fail_vec[dut_in] <= 1'b1;
                    end
                    // Last vector stays on dut_in after the run.
                    if (!last_vec)
                        dut_in <= dut_in + N_IN'(1);
                end
                DONE: begin
                    pass <= (err_cnt == '0);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GATE_TEST_SEQ_TRACE_EN
    always @(posedge clk) begin
        if (!rst && state == SAMPLE)
            $display("%0t gate_test_seq: in=%b out=%b exp=%b %s",
                     $time, dut_in, dut_out, TRUTH[dut_in],
                     miss ? "MISS" : "MATCH");
        if (!rst && state == DONE)
            $display("%0t gate_test_seq: run complete err_cnt=%0d",
                     $time, err_cnt);
    end
`endif

endmodule

// File: tb/tb_gate_test_seq.sv
module tb_gate_test_seq;
    import gate_test_seq_pkg::*;

    localparam logic [7:0] TRUTH_B = 8'b1001_0110;  // 3-input parity

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;

    // instance A: 2-input, SETTLE=1, OR table
    logic [1:0] in_a;
    logic       out_a, busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [3:0] fail_a;
    logic [3:0] gate_a = TT_OR;
    assign out_a = gate_a[in_a];

    // instance B: 3-input, SETTLE=3, parity table
    logic [2:0] in_b;
    logic       out_b, busy_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [7:0] fail_b;
    logic [7:0] gate_b = TRUTH_B;
    assign out_b = gate_b[in_b];

    gate_test_seq #(.N_IN(2), .SETTLE(1), .TRUTH(TT_OR)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(in_a), .dut_out(out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_vec(fail_a)
    );

    gate_test_seq #(.N_IN(3), .SETTLE(3), .TRUTH(TRUTH_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(in_b), .dut_out(out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_vec(fail_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // run observation log (filled by run_seq, judged by the test tasks)
    logic [2:0] log_in [64];
    int         done_at;
    int         busy_gap;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pulse (or hold) start on one instance and record dut_in / busy each
    // cycle until done rises. Cycle 0 is the cycle right after the accepting
    // edge. Leaves the bench sitting in the done cycle.
    task automatic run_seq(input bit sel, input bit hold_start);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        step;
        if (!hold_start) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
        done_at  = -1;
        busy_gap = 0;
        for (int k = 0; k < 64; k++) begin
            log_in[k] = sel ? in_b : {1'b0, in_a};
            if (!(sel ? busy_b : busy_a)) busy_gap++;
            if (sel ? done_b : done_a) begin
                done_at = k;
                break;
            end
            step;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_cmp++; if (in_a !== 2'd0)   begin n_bad++; $display("FAIL rst_in_a: got %0d want 0", in_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy_a: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rst_done_a: got %b want 0", done_a); end
        n_cmp++; if (pass_a !== 1'b0) begin n_bad++; $display("FAIL rst_pass_a: got %b want 0", pass_a); end
        n_cmp++; if (err_a !== 3'd0)  begin n_bad++; $display("FAIL rst_err_a: got %0d want 0", err_a); end
        n_cmp++; if (fail_a !== 4'd0) begin n_bad++; $display("FAIL rst_fail_a: got %b want 0", fail_a); end
        n_cmp++; if (busy_b !== 1'b0 || in_b !== 3'd0 || err_b !== 4'd0 || fail_b !== 8'd0)
            begin n_bad++; $display("FAIL rst_b: got busy=%b in=%0d err=%0d fail=%b want all 0", busy_b, in_b, err_b, fail_b); end
        step;
        step;
        rst = 1'b0;
        step;
    endtask

    // Fixed-gate run on instance A; expectations from the truth-table xor.
    task automatic test_gate_a(input logic [3:0] gate, input string name);
        int exp_err;
        logic [3:0] exp_fail;
        gate_a   = gate;
        exp_fail = gate ^ TT_OR;
        exp_err  = $countones(exp_fail);
        run_seq(1'b0, 1'b0);
        n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL %s_done_cycle: got %0d want 8", name, done_at); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (log_in[k] !== 3'(k / 2)) begin n_bad++; $display("FAIL %s_seq[%0d]: got %0d want %0d", name, k, log_in[k], k / 2); end
        end
        n_cmp++; if (busy_gap != 0) begin n_bad++; $display("FAIL %s_busy_gap: got %0d want 0", name, busy_gap); end
        n_cmp++; if (err_a !== 3'(exp_err)) begin n_bad++; $display("FAIL %s_err: got %0d want %0d", name, err_a, exp_err); end
        n_cmp++; if (fail_a !== exp_fail) begin n_bad++; $display("FAIL %s_fail_vec: got %b want %b", name, fail_a, exp_fail); end
        step;
        n_cmp++; if (pass_a !== (exp_err == 0)) begin n_bad++; $display("FAIL %s_pass: got %b want %b", name, pass_a, exp_err == 0); end
        n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL %s_idle: got busy=%b done=%b want 0 0", name, busy_a, done_a); end
        n_cmp++; if (in_a !== 2'd3) begin n_bad++; $display("FAIL %s_hold_last: got %0d want 3", name, in_a); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            int exp_err;
            logic [3:0] g;
            logic [3:0] exp_fail;
            g = 4'($urandom);
            gate_a   = g;
            exp_fail = g ^ TT_OR;
            exp_err  = $countones(exp_fail);
            run_seq(1'b0, 1'b0);
            n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL rand%0d_done_cycle: got %0d want 8", i, done_at); end
            n_cmp++; if (err_a !== 3'(exp_err)) begin n_bad++; $display("FAIL rand%0d_err: got %0d want %0d", i, err_a, exp_err); end
            n_cmp++; if (fail_a !== exp_fail) begin n_bad++; $display("FAIL rand%0d_fail_vec: got %b want %b", i, fail_a, exp_fail); end
            step;
            n_cmp++; if (pass_a !== (exp_err == 0)) begin n_bad++; $display("FAIL rand%0d_pass: got %b want %b", i, pass_a, exp_err == 0); end
            step;
        end
    endtask

    task automatic test_settle3;
        for (int r = 0; r < 3; r++) begin
            int exp_err;
            logic [7:0] exp_fail;
            gate_b   = (r == 0) ? TRUTH_B : 8'($urandom);
            exp_fail = gate_b ^ TRUTH_B;
            exp_err  = $countones(exp_fail);
            run_seq(1'b1, 1'b0);
            n_cmp++; if (done_at != 32) begin n_bad++; $display("FAIL s3_%0d_done_cycle: got %0d want 32", r, done_at); end
            for (int k = 0; k < 32; k++) begin
                n_cmp++;
                if (log_in[k] !== 3'(k / 4)) begin n_bad++; $display("FAIL s3_%0d_seq[%0d]: got %0d want %0d", r, k, log_in[k], k / 4); end
            end
            n_cmp++; if (err_b !== 4'(exp_err)) begin n_bad++; $display("FAIL s3_%0d_err: got %0d want %0d", r, err_b, exp_err); end
            n_cmp++; if (fail_b !== exp_fail) begin n_bad++; $display("FAIL s3_%0d_fail_vec: got %b want %b", r, fail_b, exp_fail); end
            step;
            n_cmp++; if (pass_b !== (exp_err == 0)) begin n_bad++; $display("FAIL s3_%0d_pass: got %b want %b", r, pass_b, exp_err == 0); end
            n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL s3_%0d_busy_end: got %b want 0", r, busy_b); end
            step;
        end
    endtask

    task automatic test_back_to_back;
        gate_a = TT_AND;
        run_seq(1'b0, 1'b1);  // start stays high through the whole run
        n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 8", done_at); end
        n_cmp++; if (busy_gap != 0) begin n_bad++; $display("FAIL b2b_busy_gap: got %0d want 0", busy_gap); end
        n_cmp++; if (log_in[5] !== 3'd2 || log_in[7] !== 3'd3) begin n_bad++; $display("FAIL b2b_no_restart: got %0d %0d want 2 3", log_in[5], log_in[7]); end
        n_cmp++; if (err_a !== 3'd2) begin n_bad++; $display("FAIL b2b_err1: got %0d want 2", err_a); end
        gate_a = TT_OR;
        step;  // IDLE cycle, start still high
        n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy_a, done_a); end
        n_cmp++; if (pass_a !== 1'b0 || err_a !== 3'd2 || fail_a !== 4'b0110)
            begin n_bad++; $display("FAIL b2b_results1: got pass=%b err=%0d fail=%b want 0 2 0110", pass_a, err_a, fail_a); end
        step;  // start accepted on this edge
        start_a = 1'b0;
        n_cmp++; if (busy_a !== 1'b1 || in_a !== 2'd0) begin n_bad++; $display("FAIL b2b_restart: got busy=%b in=%0d want 1 0", busy_a, in_a); end
        n_cmp++; if (err_a !== 3'd0 || fail_a !== 4'd0 || pass_a !== 1'b0)
            begin n_bad++; $display("FAIL b2b_cleared: got err=%0d fail=%b pass=%b want 0 0 0", err_a, fail_a, pass_a); end
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (done_a) begin done_at = k; break; end
            step;
        end
        n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL b2b_done2_cycle: got %0d want 8", done_at); end
        step;
        n_cmp++; if (pass_a !== 1'b1 || err_a !== 3'd0) begin n_bad++; $display("FAIL b2b_pass2: got pass=%b err=%0d want 1 0", pass_a, err_a); end
        step;
    endtask

    task automatic test_rst_mid;
        int done_seen;
        gate_a  = TT_AND;
        start_a = 1'b1;
        step;
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) step;   // now holding vector 2
        n_cmp++; if (in_a !== 2'd2 || err_a !== 3'd1) begin n_bad++; $display("FAIL rstmid_pre: got in=%0d err=%0d want 2 1", in_a, err_a); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (in_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_ctrl: got in=%0d busy=%b done=%b want 0 0 0", in_a, busy_a, done_a); end
        n_cmp++; if (err_a !== 3'd0 || fail_a !== 4'd0 || pass_a !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_results: got err=%0d fail=%b pass=%b want 0 0 0", err_a, fail_a, pass_a); end
        step;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_a || busy_a) done_seen++;
            step;
        end
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", done_seen); end
        gate_a = TT_OR;
        run_seq(1'b0, 1'b0);
        n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL rstmid_rerun_done: got %0d want 8", done_at); end
        step;
        n_cmp++; if (pass_a !== 1'b1 || err_a !== 3'd0) begin n_bad++; $display("FAIL rstmid_rerun_pass: got pass=%b err=%0d want 1 0", pass_a, err_a); end
    endtask

    initial begin
        test_reset;
        test_gate_a(TT_OR, "or");
        test_gate_a(TT_AND, "and");
        test_gate_a(TT_XOR, "xor");
        test_random;
        test_settle3;
        test_back_to_back;
        test_rst_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
